// File: rtl/ascii_write_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ascii_write_receiver_pkg
// Description : Shared constants and types for the ASCII write receiver:
//               cell count, clear character, field positions inside the
//               32-bit ascii_input word, and the receiver state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ascii_write_receiver_pkg;

    // 80 x 60 character screen
    localparam int unsigned NUM_CELLS_DEF  = 4800;
    localparam logic [7:0]  CLEAR_CHAR_DEF = 8'h20;
    localparam logic [7:0]  CLEAR_ATTR     = 8'h00;

    // Field layout of ascii_input / char_data
    localparam int unsigned CHAR_LSB = 0;
    localparam int unsigned ATTR_LSB = 8;
    localparam int unsigned FIELD_W  = 8;
    localparam int unsigned DATA_W   = 16;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } rx_state_e;

endpackage : ascii_write_receiver_pkg
`default_nettype wire

// File: rtl/ascii_write_receiver_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ascii_write_receiver_sync_fifo
// Description : Single-clock FIFO buffering character writes. Push and pop in
//               the same cycle are honoured at any occupancy, including full.
//               No bypass: data pushed at edge N is visible on dout from N+1.
// Ports       : clk, rst (async, active-low)
//               push / din     - write side
//               pop  / dout    - read side, dout is the current head
//               full / empty   - occupancy flags from the registered count
// Revision    : 1.0 - initial release
// ============================================================================
module ascii_write_receiver_sync_fifo #(
    parameter int unsigned WIDTH = 29,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic push_ok;
    logic pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule : ascii_write_receiver_sync_fifo
`default_nettype wire

// File: rtl/ascii_write_receiver.sv
`default_nettype none
// ============================================================================
// Module      : ascii_write_receiver
// Description : Receiving end of the ASCII write interface. Buffers character
//               writes in a FIFO and drains them into the character RAM write
//               port whenever the VGA side grants it. Also runs a hardware
//               clear-screen sequence that fills every cell with CLEAR_CHAR.
// Ports       : clk, rst (async, active-low)
//               ascii_write_en/ascii_input/ascii_write_address - write input
//               clear_req  - start (or restart) a clear-screen sequence
//               ram_grant  - char RAM write port available this cycle
//               char_we/char_addr/char_data - char RAM write port
//               busy       - clear running or writes still buffered
//               overflow   - sticky, a write was lost to a full FIFO
//               oob_drop   - pulse, a write targeted a nonexistent cell
//               clear_done - pulse, clear sequence completed
// Revision    : 1.0 - initial release
// ============================================================================
module ascii_write_receiver
    import ascii_write_receiver_pkg::*;
#(
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned NUM_CELLS  = NUM_CELLS_DEF,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  CLEAR_CHAR = CLEAR_CHAR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ascii_write_en,
    input  logic [31:0]       ascii_input,
    input  logic [ADDR_W-1:0] ascii_write_address,
    input  logic              clear_req,
    input  logic              ram_grant,
    output logic              char_we,
    output logic [ADDR_W-1:0] char_addr,
    output logic [15:0]       char_data,
    output logic              busy,
    output logic              overflow,
    output logic              oob_drop,
    output logic              clear_done
);

    localparam int unsigned       ENTRY_W   = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] CELL_LIM  = ADDR_W'(NUM_CELLS);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(NUM_CELLS - 1);

    rx_state_e         state_q,      state_d;
    logic [ADDR_W-1:0] clr_cnt_q,    clr_cnt_d;
    logic              overflow_q,   overflow_d;
    logic              oob_drop_q,   oob_drop_d;
    logic              clear_done_q, clear_done_d;

    logic               addr_in_range;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               drop_full;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_data;
    logic               unused_upper;

    // Bits [31:16] of the input word carry nothing for this block.
    assign unused_upper = ^ascii_input[31:16];

    assign addr_in_range = (ascii_write_address < CELL_LIM);
    assign push_entry    = {ascii_write_address,
                            ascii_input[ATTR_LSB +: FIELD_W],
                            ascii_input[CHAR_LSB +: FIELD_W]};

    // The head is only consumed in RUN; during CLEAR the buffer keeps filling so
    // that writes issued mid-clear overwrite the blanked cells afterwards.
    assign fifo_pop  = (state_q == ST_RUN) & ram_grant & ~fifo_empty;
    assign fifo_push = ascii_write_en & addr_in_range & (~fifo_full | fifo_pop);
    assign drop_full = ascii_write_en & addr_in_range & fifo_full & ~fifo_pop;

    ascii_write_receiver_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (push_entry),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_addr = head_entry[ENTRY_W-1 -: ADDR_W];
    assign head_data = head_entry[DATA_W-1:0];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        clear_done_d = 1'b0;
        oob_drop_d   = ascii_write_en & ~addr_in_range;
        overflow_d   = overflow_q;

        case (state_q)
            ST_RUN: begin
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clear_req) begin
                    // Restart from the first cell; no completion pulse.
                    clr_cnt_d = '0;
                end else if (ram_grant) begin
                    if (clr_cnt_q == LAST_CELL) begin
                        state_d      = ST_RUN;
                        clr_cnt_d    = '0;
                        clear_done_d = 1'b1;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d   = ST_RUN;
                clr_cnt_d = '0;
            end
        endcase

        if (clear_req) begin
            overflow_d = 1'b0;
        end else if (drop_full) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            clr_cnt_q    <= '0;
            overflow_q   <= 1'b0;
            oob_drop_q   <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            overflow_q   <= overflow_d;
            oob_drop_q   <= oob_drop_d;
            clear_done_q <= clear_done_d;
        end
    end

    // ------------------------------------------------------------------
    // RAM port: combinational from registered state. In RUN the address and
    // data are forced to zero while the FIFO is empty so nothing stale from
    // the unreset storage ever appears on the port.
    // ------------------------------------------------------------------
    always_comb begin
        char_we   = 1'b0;
        char_addr = '0;
        char_data = '0;
        case (state_q)
            ST_RUN: begin
                char_we = ram_grant & ~fifo_empty;
                if (!fifo_empty) begin
                    char_addr = head_addr;
                    char_data = head_data;
                end
            end
            ST_CLEAR: begin
                char_we   = ram_grant;
                char_addr = clr_cnt_q;
                char_data = {CLEAR_ATTR, CLEAR_CHAR};
            end
            default: begin
                char_we = 1'b0;
            end
        endcase
    end

    assign busy       = (state_q == ST_CLEAR) | ~fifo_empty;
    assign overflow   = overflow_q;
    assign oob_drop   = oob_drop_q;
    assign clear_done = clear_done_q;

endmodule : ascii_write_receiver
`default_nettype wire
